uart_rx_framed: RTL
===================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver.
//  - Configurable data width, parity and stop-bit count; LSB-first serial input.
//  - Double-flop input synchroniser and false-start rejection.
//  - Frame and parity error reporting; valid/ready output with one holding register and overrun detection.
//  - Sits between the board RX pin and the command/FIFO logic.
// PARAMETERS
//  CLOCK_FREQ  12000000  system clock in Hz
//  BAUD_RATE   115200    line rate; CLKS_PER_BIT=CLOCK_FREQ/BAUD_RATE (integer division), must be >=4
//  DATA_BITS   8         data bits per frame, legal range 5..9
//  PARITY      0         0=none, 1=odd, 2=even (only active with UART_RX_PARITY_EN)
//  STOP_BITS   1         1 or 2
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  reset_n     in   1          asynchronous, active-low reset
//  rx          in   1          serial line, idle high, asynchronous to clk
//  out_data    out  DATA_BITS  received word, LSB = first data bit on line
//  out_valid   out  1          out_data/out_frame_err/out_parity_err are valid
//  out_ready   in   1          consumer accepts the word when out_valid&&out_ready
//  out_frame_err  out 1        a stop bit sampled 0; travels with the word
//  out_parity_err out 1        parity mismatch; travels with the word; 0 when parity is off
//  overrun     out  1          1-cycle pulse: a word completed while the holding register was full
//  rx_busy     out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, sync flops=1. Reset asserted mid-frame aborts the frame with no output.
//  - rx passes through 2 flops to give rx_s (2-cycle latency). Bit counter runs 0..CLKS_PER_BIT-1. HALF=CLKS_PER_BIT/2.
//  - FSM states:
//    - IDLE: rx_s==0 -> START, counter cleared.
//    - START: at count HALF-1, sample rx_s. If 0 -> DATA, counter cleared. If 1 -> IDLE (glitch, no output, no error).
//    - DATA: at count CLKS_PER_BIT-1, shift rx_s in LSB-first. After DATA_BITS samples -> PARITY if enabled, else STOP.
//    - PARITY: sample one bit. Odd parity: XOR(data, p) must be 1. Even parity: XOR(data, p) must be 0. -> STOP.
//    - STOP: sample STOP_BITS bits. Any stop sample 0 sets frame_err. After the last stop sample the word completes.
//      - frame_err=0 -> IDLE.
//      - frame_err=1 -> WAIT_IDLE.
//    - WAIT_IDLE: stays until rx_s==1 (break/line-low protection), then -> IDLE.
//  - Completion (cycle after the last stop sample):
//    - Holding register empty, or draining this same cycle (out_valid&&out_ready): load out_data and both error
//      flags; set out_valid=1. No overrun.
//    - Holding register full and not draining: the new word is dropped; the held word and its flags are unchanged;
//      overrun=1 for one cycle.
//  - Handshake: out_valid stays high and out_* stay stable until out_valid&&out_ready. out_valid drops the cycle
//    after acceptance unless a new word loads in that same cycle.
//  - Latency: the frame's start edge reaches rx_s after 2 clk.
//    Sampling begins at that rx_s edge and runs (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT+HALF cycles, where P=1 if parity is active.
//    out_valid rises 1 cycle after that.
//  - A falling edge during the second half of the last stop bit is caught from IDLE: back-to-back frames are received.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY parameter honoured; the PARITY state exists.
//    - Legal PARITY values are 0, 1 and 2.
//  UART_RX_PARITY_EN undefined:
//    - No PARITY state and no parity logic.
//    - PARITY is ignored and out_parity_err is tied to 0.
//    - Frame length is 1+DATA_BITS+STOP_BITS bits.
// STRUCTURE
//  - Shared header uart_defs.vh holds:
//    - parity encodings UART_PARITY_NONE/ODD/EVEN = 0/1/2;
//    - FSM state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), shared with a future transmitter;
//    - a CLKS_PER_BIT computation macro.
//  - One sub-module: uart_rx_sync, a 2-flop synchroniser with reset value 1.
//  - FSM, counters, shift register and holding register stay in this module.
// TESTING  (bench: CLOCK_FREQ=4, BAUD_RATE=1, so CLKS_PER_BIT=4; out_ready=1 unless stated)
//  1. 8N1, rx sends 8'hA5 -> out_valid pulses, out_data=8'hA5, out_frame_err=0, out_parity_err=0, overrun=0.
//  2. Macro on, PARITY=2, send 8'h07 with parity bit 1 -> data 8'h07, parity_err=0.
//     Resend with parity bit 0 -> parity_err=1.
//  3. Stop bit driven 0 after 8'h3C, rx then held low for 40 cycles -> one word 8'h3C with out_frame_err=1.
//     No further out_valid until rx returns high; the next frame 8'h81 is received correctly.
//  4. rx low for 1 cycle only -> START rejects it: no out_valid; rx_busy returns to 0 within HALF+3 cycles.
//  5. out_ready=0; send 8'h11 then 8'h22 back-to-back -> out_data holds 8'h11 and overrun pulses once.
//     After out_ready=1, 8'h11 is accepted and no 8'h22 is presented.
//  6. reset_n pulsed low mid-DATA of 8'hF0 -> all outputs 0 at once; a subsequent 8'h5A frame is received correctly.
//  Also: DATA_BITS=5/STOP_BITS=2 and DATA_BITS=9 builds; macro-off build with PARITY=1 behaves as 8N1.

Source files
------------

// File: rtl/uart_rx_framed_pkg.sv
// Shared UART definitions: parity encodings, FSM state encodings, bit-period helper.
// The state encodings are meant to be reused by a future transmitter.
package uart_rx_framed_pkg;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_ODD  = 1;
  localparam int UART_PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_framed_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; resets to the idle-high line level.
module uart_rx_framed_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with false-start rejection, frame/parity errors and an output holding register.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_framed
  import uart_rx_framed_pkg::*;
#(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_frame_err,
  output logic                 out_parity_err,
  output logic                 overrun,
  output logic                 rx_busy,
  output logic [2:0]           dbg_state_o
);

  localparam int CPB  = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < UART_PARITY_NONE || PARITY > UART_PARITY_EVEN) begin : g_bad_param
    $error("uart_rx_framed: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != UART_PARITY_NONE);
  localparam bit PAR_ODD = (PARITY == UART_PARITY_ODD);
`endif

  logic rx_s;

  uart_rx_framed_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 complete;
  logic                 bit_tick;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 oferr_q;
  logic                 operr_q;
  logic                 overrun_q;

  assign bit_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          bit_d   = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      // Mid-start-bit re-check: a line that is high again was only a glitch.
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PAR_ON ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          perr_d  = PAR_ODD ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_s;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d    = '0;
            complete = 1'b1;
            state_d  = ferr_d ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output handshake: a word is transferred on a cycle where out_valid && out_ready;
  // out_valid and out_* hold steady until then. A completing word may load into a
  // register that is draining the same cycle; otherwise a full register drops it and flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      oferr_q   <= 1'b0;
      operr_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= complete && valid_q && !out_ready;
      if (complete && (!valid_q || out_ready)) begin
        data_q  <= shift_q;
        oferr_q <= ferr_d;
        operr_q <= perr_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_frame_err = oferr_q;
`ifdef UART_RX_PARITY_EN
  assign out_parity_err = operr_q;
`else
  assign out_parity_err = 1'b0;
`endif
  assign overrun     = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
